// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and address helpers for the data RAM arbiter
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DMEM_DEPTH = 1024;
    localparam int unsigned IDX_W      = $clog2(DMEM_DEPTH);

    // Word-aligned and inside [base, base + WORD_BYTES*depth); 33-bit compare so the
    // window end never wraps.
    function automatic logic addr_in_window(input logic [31:0]  addr,
                                            input logic [31:0]  base,
                                            input int unsigned  depth);
        logic [32:0] lim;
        lim = {1'b0, base} + 33'(WORD_BYTES * depth);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim) && (addr[1:0] == 2'b00);
    endfunction

    // Byte address to word index relative to the window base (caller truncates).
    function automatic logic [31:0] addr_to_word(input logic [31:0] addr,
                                                 input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// rtl/dmem_rr_arb2.sv - two-way arbiter with optional round-robin tie break
module dmem_rr_arb2
    import dmem_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // Port favoured on a tie; moves to the other port after each grant.
    logic prio_q, prio_d;

    // Pick the winner: a lone requester wins outright, a tie goes to the favoured port.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (RR_EN && prio_q) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        prio_d = prio_q;
        if (update_i && (gnt_o != 2'b00)) begin
            prio_d = gnt_o[0];
        end
    end

    // Pointer register, port 0 favoured out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - clears the data RAM after reset, then shares it between CPU and DMA ports
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = DMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter bit          RR_EN     = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p0_req,
    input  logic                     p0_we,
    input  logic [31:0]              p0_addr,
    input  logic [31:0]              p0_wdata,
    output logic                     p0_gnt,
    output logic                     p0_rvalid,
    output logic [31:0]              p0_rdata,
    output logic                     p0_err,
    input  logic                     p1_req,
    input  logic                     p1_we,
    input  logic [31:0]              p1_addr,
    input  logic [31:0]              p1_wdata,
    output logic                     p1_gnt,
    output logic                     p1_rvalid,
    output logic [31:0]              p1_rdata,
    output logic                     p1_err,
    output logic                     mem_wr_en,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_din,
    input  logic [31:0]              mem_dout,
    output logic                     init_busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_hold_q;

    logic            rsp_valid_q;
    logic            rsp_port_q;
    logic            rsp_err_q;
    logic            rsp_rd_q;

    logic            active;
    logic [1:0]      gnt;
    logic            any_gnt;
    logic            sel;
    logic            sel_we;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_ok;
    logic            rsp_live;

    // Requests are only visible to the arbiter once the sweep is done and reset is low.
    assign active = (state_q == RUN) && !reset;

    dmem_rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({p1_req, p0_req} & {2{active}}),
        .update_i (active),
        .gnt_o    (gnt)
    );

    assign any_gnt   = gnt[0] | gnt[1];
    assign sel       = gnt[1];
    assign sel_we    = sel ? p1_we    : p0_we;
    assign sel_addr  = sel ? p1_addr  : p0_addr;
    assign sel_wdata = sel ? p1_wdata : p0_wdata;
    assign sel_ok    = addr_in_window(sel_addr, BASE_ADDR, DEPTH);

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];

    // Sweep/run control and RAM port drive; the address bus holds when nothing is accessed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_wr_en = 1'b0;
        mem_addr  = addr_hold_q;
        mem_din   = 32'h0;
        init_busy = 1'b0;
        case (state_q)
            INIT: begin
                if (!reset) begin
                    init_busy = 1'b1;
                    mem_wr_en = 1'b1;
                    mem_addr  = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (any_gnt && sel_ok) begin
                    mem_addr = AW'(addr_to_word(sel_addr, BASE_ADDR));
                    if (sel_we) begin
                        mem_wr_en = 1'b1;
                        mem_din   = sel_wdata;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State, sweep counter, held address and the one-deep response pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            addr_hold_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_hold_q <= mem_addr;
            rsp_valid_q <= any_gnt;
            rsp_port_q  <= sel;
            rsp_err_q   <= !sel_ok;
            rsp_rd_q    <= !sel_we && sel_ok;
        end
    end

    // A response already in flight is suppressed as soon as reset is raised.
    assign rsp_live  = rsp_valid_q && !reset;
    assign p0_rvalid = rsp_live && !rsp_port_q;
    assign p1_rvalid = rsp_live &&  rsp_port_q;
    assign p0_err    = p0_rvalid && rsp_err_q;
    assign p1_err    = p1_rvalid && rsp_err_q;
    assign p0_rdata  = (p0_rvalid && rsp_rd_q) ? mem_dout : 32'h0;
    assign p1_rdata  = (p1_rvalid && rsp_rd_q) ? mem_dout : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] BASE  = 32'h0000_0400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_wr_en, init_busy;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_din, mem_dout;

    logic        fp_p0_gnt, fp_p0_rvalid, fp_p0_err, fp_p1_gnt, fp_p1_rvalid, fp_p1_err;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_din;
    logic        fp_mem_wr_en, fp_init_busy;
    logic [AW-1:0] fp_mem_addr;

    dmem_arbiter #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .init_busy(init_busy)
    );

    dmem_arbiter #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata), .p0_err(fp_p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata), .p1_err(fp_p1_err),
        .mem_wr_en(fp_mem_wr_en), .mem_addr(fp_mem_addr), .mem_din(fp_mem_din),
        .mem_dout(32'h0), .init_busy(fp_init_busy)
    );

    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } req_t;
    typedef struct { int due; bit err; logic [31:0] rdata; } rsp_t;

    req_t        cur [2];
    bit          pend [2];
    int          last_win;
    logic [31:0] ref_mem [DEPTH];
    int          exp_hold;
    rsp_t        rq [2][$];
    int          checks = 0, failures = 0;
    int          cyc = 0;
    bit          mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH) && (la % 4 == 0);
    endfunction

    task automatic drive();
        p0_req = pend[0]; p0_we = cur[0].we; p0_addr = cur[0].addr; p0_wdata = cur[0].data;
        p1_req = pend[1]; p1_we = cur[1].we; p1_addr = cur[1].addr; p1_wdata = cur[1].data;
    endtask

    task automatic set_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        cur[p].we = we; cur[p].addr = a; cur[p].data = d; pend[p] = 1;
    endtask

    task automatic rand_req(input int p);
        int r;
        logic [31:0] a;
        r = $urandom_range(99);
        if (r < 8) begin
            case ($urandom_range(3))
                0: a = 32'h0000_03FC;
                1: a = BASE + 4 * DEPTH;
                2: a = BASE + 4 * $urandom_range(15) + $urandom_range(3, 1);
                default: a = 32'hFFFF_FFFC;
            endcase
        end else if (r < 60) begin
            a = BASE + 4 * $urandom_range(7);
        end else begin
            a = BASE + 4 * $urandom_range(DEPTH - 1);
        end
        set_req(p, 1'($urandom_range(1)), a, $urandom);
    endtask

    // One RUN-phase cycle: new requests after the edge, model decision at the falling edge.
    task automatic run_cycle(input int rate0, input int rate1);
        int win, idx;
        bit ok;
        rsp_t e;
        @(posedge clk); #1;
        if (!pend[0] && $urandom_range(99) < rate0) rand_req(0);
        if (!pend[1] && $urandom_range(99) < rate1) rand_req(1);
        drive();
        @(negedge clk);
        win = -1;
        if (pend[0] && pend[1]) win = (last_win == 0) ? 1 : 0;
        else if (pend[0])       win = 0;
        else if (pend[1])       win = 1;
        chk("init_busy_run", init_busy, 0);
        chk("p0_gnt", p0_gnt, win == 0);
        chk("p1_gnt", p1_gnt, win == 1);
        chk("fp_p0_gnt", fp_p0_gnt, pend[0]);
        chk("fp_p1_gnt", fp_p1_gnt, pend[1] && !pend[0]);
        ok = 0;
        if (win >= 0) begin
            ok  = legal(cur[win].addr);
            idx = ok ? int'((cur[win].addr - BASE) / 4) : 0;
            e.due   = cyc + 1;
            e.err   = !ok;
            e.rdata = (ok && !cur[win].we) ? ref_mem[idx] : 32'h0;
            rq[win].push_back(e);
            if (ok) begin
                exp_hold = idx;
                if (cur[win].we) ref_mem[idx] = cur[win].data;
            end
            last_win = win;
            pend[win] = 0;
        end
        chk("mem_wr_en", mem_wr_en, (win >= 0) && ok && cur[win].we);
        chk("mem_addr", 32'(mem_addr), exp_hold);
        if ((win >= 0) && ok && cur[win].we) chk("mem_din", mem_din, cur[win].data);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1;
        pend[0] = 0; pend[1] = 0;
        drive();
        rq[0].delete(); rq[1].delete();
        last_win = 1;
        repeat (n) begin
            @(negedge clk);
            chk("rst_p0_rvalid", p0_rvalid, 0);
            chk("rst_p1_rvalid", p1_rvalid, 0);
            chk("rst_p0_gnt", p0_gnt, 0);
            chk("rst_p1_gnt", p1_gnt, 0);
            chk("rst_mem_wr_en", mem_wr_en, 0);
            chk("rst_p0_rdata", p0_rdata, 0);
            chk("rst_p0_err", p0_err, 0);
        end
        @(posedge clk); #1;
        reset = 0;
    endtask

    // Clear sweep: DEPTH cycles of zero writes to 0..DEPTH-1, no grants even if requested.
    task automatic check_sweep(input bit req_late);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("sweep_busy", init_busy, 1);
            chk("sweep_wr_en", mem_wr_en, 1);
            chk("sweep_addr", 32'(mem_addr), i);
            chk("sweep_din", mem_din, 0);
            chk("sweep_p0_gnt", p0_gnt, 0);
            chk("sweep_p1_gnt", p1_gnt, 0);
            chk("sweep_fp_gnt", fp_p0_gnt, 0);
            if (req_late && i == DEPTH - 4) begin
                set_req(0, 0, BASE + 32'h10, 0);
                drive();
            end
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        exp_hold = DEPTH - 1;
    endtask

    // Response monitor: every expected response must appear exactly one cycle after its grant.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < 2; p++) begin
                logic        rv, er;
                logic [31:0] rd;
                bit          exp_now;
                rsp_t        m;
                rv = (p == 0) ? p0_rvalid : p1_rvalid;
                er = (p == 0) ? p0_err    : p1_err;
                rd = (p == 0) ? p0_rdata  : p1_rdata;
                exp_now = (rq[p].size() > 0) && (rq[p][0].due == cyc);
                chk($sformatf("p%0d_rvalid", p), rv, exp_now);
                if (exp_now) begin
                    m = rq[p].pop_front();
                    if (rv) begin
                        chk($sformatf("p%0d_err", p), er, m.err);
                        chk($sformatf("p%0d_rdata", p), rd, m.rdata);
                    end
                end
            end
        end
    end

    initial begin
        pend[0] = 0; pend[1] = 0;
        cur[0] = '{0, 0, 0}; cur[1] = '{0, 0, 0};
        last_win = 1;
        exp_hold = 0;
        do_reset(3);
        mon_en = 1;
        check_sweep(1);
        run_cycle(0, 0);
        run_cycle(0, 0);

        set_req(0, 1, 32'h0000_0404, 32'hDEAD_BEEF);
        run_cycle(0, 0);
        set_req(0, 0, 32'h0000_0404, 32'h0);
        run_cycle(0, 0);
        run_cycle(0, 0);

        set_req(1, 0, 32'h0000_03FC, 32'h0);
        run_cycle(0, 0);
        set_req(1, 1, 32'h0000_0802, 32'h1234_5678);
        run_cycle(0, 0);
        set_req(0, 0, 32'h0000_1400, 32'h0);
        run_cycle(0, 0);
        run_cycle(0, 0);

        repeat (20)  run_cycle(100, 100);
        repeat (400) run_cycle(50, 50);
        repeat (4)   run_cycle(0, 0);

        repeat (10) run_cycle(100, 0);
        do_reset(4);
        check_sweep(0);
        repeat (60) run_cycle(70, 70);
        repeat (4)  run_cycle(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
